rf_wb_arbiter: RTL

- Shares the single register-unit write port (rd / RuWr / DataWr) between two writeback sources.
  - Source A: main pipeline writeback.
  - Source B: long-latency unit writeback (mul/div, load return).
- Source A has fixed priority. A starvation counter forces a grant to B after MAX_WAIT lost cycles.
- Output is registered, one write per cycle. Writes to x0 are accepted but suppressed at the write port.

---
 rtl/rf_wb_arbiter_if.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus shared by the two writeback sources and the register-unit write port.
// master: the side that presents writebacks and observes the write port; slave: the arbiter.
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32
);
    // valid/ready: a source raises valid with rd/data and holds all three unchanged until
    // it sees ready high on a rising edge; that edge is the transfer.
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;

    logic            b_valid;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;

    logic [4:0]      rd;
    logic            RuWr;
    logic [XLEN-1:0] DataWr;
    logic            starve_force;

    modport master (
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        input  rd, RuWr, DataWr, starve_force
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        output rd, RuWr, DataWr, starve_force
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-unit write port between the pipeline (A, fixed priority)
// and the long-latency unit (B), forcing B through after MAX_WAIT consecutive lost cycles.
module rf_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wb_arbiter_if.slave      bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    typedef enum logic {
        MODE_A_PRIO   = 1'b0,
        MODE_B_FORCED = 1'b1
    } arb_mode_e;

    arb_mode_e       mode_q, mode_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            wr_q, wr_d;

    logic            a_grant;
    logic            b_grant;

    // Grants are gated by rst_n so neither source sees a handshake while reset is held.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst_n) begin
            if (mode_q == MODE_B_FORCED) begin
                b_grant = bus.b_valid;
                a_grant = bus.a_valid && !bus.b_valid;
            end else begin
                a_grant = bus.a_valid;
                b_grant = bus.b_valid && !bus.a_valid;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.b_valid || b_grant) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        mode_d = (wait_cnt_d == MAX_CNT) ? MODE_B_FORCED : MODE_A_PRIO;
    end

    // x0 writebacks complete the handshake but never raise the write enable.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        wr_d   = 1'b0;
        if (a_grant) begin
            rd_d   = bus.a_rd;
            data_d = bus.a_data;
            wr_d   = (bus.a_rd != 5'd0);
        end else if (b_grant) begin
            rd_d   = bus.b_rd;
            data_d = bus.b_data;
            wr_d   = (bus.b_rd != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_A_PRIO;
            wait_cnt_q <= 4'd0;
            rd_q       <= 5'd0;
            data_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.a_ready      = a_grant;
    assign bus.b_ready      = b_grant;
    assign bus.rd           = rd_q;
    assign bus.RuWr         = wr_q;
    assign bus.DataWr       = data_q;
    assign bus.starve_force = (mode_q == MODE_B_FORCED);

endmodule
